gemm_tiled_controller: RTL
==========================

Name: gemm_tiled_controller

Overview:
Next-generation controller for the tiled GeMM accelerator. It walks the M/N/K tile loops, with the loop order chosen at run time, and issues one tile-beat per input handshake. It tracks the MAC-array pipeline latency so result beats are flagged exactly when the array produces them, and it applies output backpressure. It sits between the top-level start/config registers and the address generators and MAC-array datapath.

Parameters:
AddrWidth, 16, width of size inputs, tile counters and result counter
TileM, 4, rows of C produced in parallel (M-dimension spatial unroll)
TileK, 4, K-dimension spatial unroll per beat
TileN, 4, columns of C produced in parallel (N-dimension spatial unroll)
PipeDepth, 2, MAC-array latency in cycles, from an issued beat to its accumulator output; must be >= 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start request; sampled only in Idle
order_i  in  1  loop order, latched at start: 0 = M,N,K (M outer); 1 = N,M,K (N outer); K is always innermost
M_size_i / K_size_i / N_size_i  in  AddrWidth each  matrix sizes, latched at start
input_valid_i  in  1  operand beat available
input_ready_o  out  1  controller accepts a beat
output_ready_i  in  1  consumer accepts the result beat
result_valid_o  out  1  accumulator output holds a finished C tile
acc_clear_o  out  1  issued beat is the first K beat of its tile (datapath restarts accumulation)
pipe_en_o  out  1  MAC-array pipeline advance enable
M_count_o / K_count_o / N_count_o  out  AddrWidth each  tile indices of the beat currently offered for issue
result_count_o  out  AddrWidth  number of result beats accepted in this run
busy_o  out  1  high in Run and Drain
done_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle pulse on an illegal config

Behaviour:
- Reset: state Idle; all counters 0; pipeline tags 0; all 1-bit outputs 0.
- Asynchronous reset mid-operation aborts the run immediately. There is no partial done_o.
- Ceilings: Mt = M_size/TileM, Kt = K_size/TileK, Nt = N_size/TileN, computed from the latched sizes.
- A config is illegal if any size is 0 or any size is not a multiple of its tile.
- States: Idle, Run, Drain, Done.
- Idle: counters held clear.
  - start_i with a legal config: latch the config, go to Run.
  - start_i with an illegal config: err_o = 1 for one cycle, stay in Idle.
- Stall condition: stall = result_valid_o && !output_ready_i.
- pipe_en_o = !stall.
- Run:
  - input_ready_o = !stall.
  - fire = input_valid_i && input_ready_o.
  - acc_clear_o = fire && K_count_o == 0.
  - On fire, K increments. On K wrap, the middle counter increments (N if order 0, M if order 1). On middle wrap, the outer counter increments.
  - A fire on which all three counters are at their last value is the final beat. After it, counters hold their values and the state goes to Drain.
- Tag pipeline: a PipeDepth-deep shift register.
  - It advances only when pipe_en_o = 1.
  - The head loads 1 on a fire with K_count_o == Kt-1, else 0. Bubbles load 0.
  - result_valid_o = tail tag.
- Latency: with no stall, result_valid_o rises exactly PipeDepth cycles after the fire of the last K beat.
- While stalled, the tags, the counters and the datapath are frozen, and result_valid_o stays high until output_ready_i.
- result_count_o increments on result_valid_o && output_ready_i.
- Drain:
  - input_ready_o = 0. Tags keep shifting.
  - When all tags are 0 and no result is pending, go to Done.
- Done: done_o = 1 for one cycle, clear the counters, go to Idle.
- result_count_o holds its value until the next legal start, where it clears.
- start_i while busy_o is ignored.
- Kt = 1: every fire sets acc_clear_o and marks its tag.
- Simultaneous last-beat fire and stall release are both honoured in the same cycle.

Test Plan:
- Basic run: TileM/K/N = 4, PipeDepth = 2, sizes 8/8/8, order 0, input_valid_i and output_ready_i tied high -> 8 fires. Issue (M,N,K) sequence is (0,0,0), (0,0,1), (0,1,0) … (1,1,1). acc_clear_o on fires 1,3,5,7. result_valid_o in cycles fire2+2, fire4+2, fire6+2, fire8+2. result_count_o = 4. done_o pulses once, then Idle.
- Loop order: same sizes, order 1 -> (M,N) tile sequence is (0,0), (1,0), (0,1), (1,1); 4 results.
- Backpressure: output_ready_i low for 5 cycles when the first result appears -> result_valid_o held for 6 cycles, input_ready_o = 0, pipe_en_o = 0, counters frozen. No beat lost; result_count_o = 4 at end.
- Illegal config: K_size = 6, or M_size = 0 -> err_o single pulse, busy_o stays 0, no fires.
- Kt = 1 with sparse input (sizes 4/4/8, input_valid_i toggling every cycle) -> every fire has acc_clear_o = 1. 2 results, each PipeDepth cycles after its fire.
- Reset mid-run: assert rst_ni low after fire 3 -> all outputs 0 immediately, state Idle, no done_o. A fresh start then completes normally.

Source files
------------

// File: rtl/gemm_tiled_controller_if.sv
// Operand/result handshake and MAC-array control between the GeMM controller and its datapath.
interface gemm_tiled_controller_if;
    logic input_valid_i;
    logic input_ready_o;
    logic output_ready_i;
    logic result_valid_o;
    logic acc_clear_o;
    logic pipe_en_o;

    modport master (
        input  input_valid_i,
        input  output_ready_i,
        output input_ready_o,
        output result_valid_o,
        output acc_clear_o,
        output pipe_en_o
    );

    modport slave (
        output input_valid_i,
        output output_ready_i,
        input  input_ready_o,
        input  result_valid_o,
        input  acc_clear_o,
        input  pipe_en_o
    );
endinterface

// File: rtl/gemm_tiled_controller.sv
// Tiled GeMM loop controller: walks M/N/K tiles in a run-time order, tracks MAC-array
// latency with a tag pipeline and freezes everything under output backpressure.
module gemm_tiled_controller #(
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned TileM     = 4,
    parameter int unsigned TileK     = 4,
    parameter int unsigned TileN     = 4,
    parameter int unsigned PipeDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 order_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] K_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    gemm_tiled_controller_if.master bus,
    output logic [AddrWidth-1:0] M_count_o,
    output logic [AddrWidth-1:0] K_count_o,
    output logic [AddrWidth-1:0] N_count_o,
    output logic [AddrWidth-1:0] result_count_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    localparam int unsigned TagW = PipeDepth;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic                 order_q;
    logic [AddrWidth-1:0] mt_q, kt_q, nt_q;
    logic [AddrWidth-1:0] m_q, k_q, n_q, res_q;
    logic [TagW-1:0]      tag_q;
    logic                 done_q, err_q, busy_q;

    logic cfg_legal, stall, last_k, last_m, last_n, last_mid, last_out;
    logic ready, pipe_en, fire, acc_clear, final_beat, start_ok, start_bad;

    assign cfg_legal = (M_size_i != '0) && ((M_size_i % AddrWidth'(TileM)) == '0) &&
                       (K_size_i != '0) && ((K_size_i % AddrWidth'(TileK)) == '0) &&
                       (N_size_i != '0) && ((N_size_i % AddrWidth'(TileN)) == '0);

    assign stall    = tag_q[TagW-1] && !bus.output_ready_i;
    assign last_k   = (k_q == kt_q - AddrWidth'(1));
    assign last_m   = (m_q == mt_q - AddrWidth'(1));
    assign last_n   = (n_q == nt_q - AddrWidth'(1));
    assign last_mid = order_q ? last_m : last_n;
    assign last_out = order_q ? last_n : last_m;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next state and issue-side handshake; the pipeline only runs while a job is active.
    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        pipe_en    = 1'b0;
        fire       = 1'b0;
        acc_clear  = 1'b0;
        final_beat = 1'b0;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (cfg_legal) begin
                        start_ok = 1'b1;
                        state_d  = StRun;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            StRun: begin
                pipe_en    = !stall;
                ready      = !stall;
                fire       = bus.input_valid_i && !stall;
                acc_clear  = fire && (k_q == '0);
                final_beat = fire && last_k && last_mid && last_out;
                if (final_beat) state_d = StDrain;
            end
            StDrain: begin
                pipe_en = !stall;
                if (tag_q == '0) state_d = StDrain == state_q ? StDone : state_q;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Latched config and tile counters; K innermost, middle/outer selected by order_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            order_q <= 1'b0;
            mt_q    <= '0;
            kt_q    <= '0;
            nt_q    <= '0;
            m_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
        end else if (start_ok) begin
            order_q <= order_i;
            mt_q    <= M_size_i / AddrWidth'(TileM);
            kt_q    <= K_size_i / AddrWidth'(TileK);
            nt_q    <= N_size_i / AddrWidth'(TileN);
            m_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
        end else if (state_q == StDone) begin
            m_q <= '0;
            k_q <= '0;
            n_q <= '0;
        end else if (fire && !final_beat) begin
            if (!last_k) begin
                k_q <= k_q + AddrWidth'(1);
            end else begin
                k_q <= '0;
                if (order_q) begin
                    if (last_m) begin
                        m_q <= '0;
                        n_q <= n_q + AddrWidth'(1);
                    end else begin
                        m_q <= m_q + AddrWidth'(1);
                    end
                end else begin
                    if (last_n) begin
                        n_q <= '0;
                        m_q <= m_q + AddrWidth'(1);
                    end else begin
                        n_q <= n_q + AddrWidth'(1);
                    end
                end
            end
        end
    end

    // Tag pipeline mirrors the MAC array: a 1 enters with the last K beat of each tile.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      tag_q <= '0;
        else if (pipe_en) tag_q <= (tag_q << 1) | TagW'(fire && last_k);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                     res_q <= '0;
        else if (start_ok)                               res_q <= '0;
        else if (tag_q[TagW-1] && bus.output_ready_i)    res_q <= res_q + AddrWidth'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= (state_d == StDone);
            err_q  <= start_bad;
            busy_q <= (state_d == StRun) || (state_d == StDrain);
        end
    end

    assign bus.input_ready_o  = ready;
    assign bus.pipe_en_o      = pipe_en;
    assign bus.acc_clear_o    = acc_clear;
    assign bus.result_valid_o = tag_q[TagW-1];
    assign M_count_o          = m_q;
    assign K_count_o          = k_q;
    assign N_count_o          = n_q;
    assign result_count_o     = res_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign err_o              = err_q;
endmodule
